// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA window limits, colour constants and lamp placement helper
//
// Contents:
//   H_ACTIVE_START, H_ACTIVE_END : visible hcount window [start, end)
//   COL_*                        : 24-bit {r,g,b} colour constants
//   light_x()                    : left edge of lamp i for a given geometry
package vga_pkg;

    localparam int H_ACTIVE_START = 144;
    localparam int H_ACTIVE_END   = 784;

    localparam logic [23:0] COL_BLACK    = 24'h000000;
    localparam logic [23:0] COL_BG_BLUE  = 24'h000080;
    localparam logic [23:0] COL_LAMP_ON  = 24'hFFFF00;
    localparam logic [23:0] COL_LAMP_OFF = 24'hB2BEB5;

    // Lamp 0 is rightmost; lamps at or beyond the split sit one group gap further left.
    function automatic int light_x(input int i, input int light0_x, input int pitch,
                                   input int split, input int group_gap);
        return light0_x - i * pitch - ((i >= split) ? group_gap : 0);
    endfunction

endpackage

// File: rtl/frame_blink_timer.sv
// rtl/frame_blink_timer.sv - per-frame snapshot strobe, blink frame counter and frame tick
//
// Ports:
//   clk, reset_n  : pixel clock, asynchronous active-low reset
//   hcount/vcount : current raster position
//   snap          : combinational, high on the snapshot pixel (hcount 0, vcount SNAP_LINE)
//   blink_phase   : toggles every BLINK_FRAMES snapshots; 0 after reset
//   frame_tick    : one-cycle pulse on the cycle after each snapshot
module frame_blink_timer #(
    parameter int SNAP_LINE    = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    output logic       snap,
    output logic       blink_phase,
    output logic       frame_tick
);

    localparam int              CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [9:0]      SNAP_V   = 10'(SNAP_LINE);

    if (BLINK_FRAMES < 1) begin : g_chk_blink
        $fatal(1, "frame_blink_timer: BLINK_FRAMES must be >= 1");
    end

    logic [CNT_W-1:0] frame_cnt;

    assign snap = (hcount == 10'd0) && (vcount == SNAP_V);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            frame_tick  <= 1'b0;
        end else begin
            frame_tick <= snap;
            if (snap) begin
                if (frame_cnt == CNT_LAST) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/light_bar_gen.sv
// rtl/light_bar_gen.sv - registered VGA renderer for a split row of square indicator lamps
//
// Ports:
//   clk, reset_n          : pixel clock, asynchronous active-low reset
//   bright, hcount, vcount: from the VGA timing controller
//   leds, blink_en        : per-lamp on-request and blink enable, sampled once per frame
//   vga_r/g/b             : pixel colour, 2 cycles after hcount/vcount/bright
//   bright_out            : bright delayed to line up with vga_r/g/b
//   frame_tick            : one-cycle pulse after each frame snapshot
module light_bar_gen
    import vga_pkg::*;
#(
    parameter int NUM_LIGHTS   = 6,
    parameter int SPLIT        = 3,
    parameter int LIGHT0_X     = 664,
    parameter int PITCH        = 80,
    parameter int GROUP_GAP    = 40,
    parameter int BOX_W        = 40,
    parameter int V_TOP        = 229,
    parameter int BOX_H        = 31,
    parameter int SNAP_LINE    = 0,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  bright,
    input  logic [9:0]            hcount,
    input  logic [9:0]            vcount,
    input  logic [NUM_LIGHTS-1:0] leds,
    input  logic [NUM_LIGHTS-1:0] blink_en,
    output logic [7:0]            vga_r,
    output logic [7:0]            vga_g,
    output logic [7:0]            vga_b,
    output logic                  bright_out,
    output logic                  frame_tick
);

    localparam logic [9:0] V_LO = 10'(V_TOP);
    localparam logic [9:0] V_HI = 10'(V_TOP + BOX_H);
    localparam logic [9:0] A_LO = 10'(H_ACTIVE_START);
    localparam logic [9:0] A_HI = 10'(H_ACTIVE_END);

    if (PITCH < BOX_W) begin : g_chk_pitch
        $fatal(1, "light_bar_gen: PITCH must be >= BOX_W");
    end
    if (SPLIT > NUM_LIGHTS) begin : g_chk_split
        $fatal(1, "light_bar_gen: SPLIT must be <= NUM_LIGHTS");
    end
    if (NUM_LIGHTS > 16 || NUM_LIGHTS < 1) begin : g_chk_num
        $fatal(1, "light_bar_gen: NUM_LIGHTS must be 1..16");
    end

    logic                  snap;
    logic                  blink_phase;
    logic [NUM_LIGHTS-1:0] leds_q;
    logic [NUM_LIGHTS-1:0] blink_q;
    logic [NUM_LIGHTS-1:0] lit;
    logic [NUM_LIGHTS-1:0] hit_now;

    logic [NUM_LIGHTS-1:0] hit_s1;
    logic                  in_band_s1;
    logic                  in_active_s1;
    logic                  bright_s1;

    logic [23:0]           rgb_q;
    logic [23:0]           rgb_next;

    frame_blink_timer #(
        .SNAP_LINE    (SNAP_LINE),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .hcount      (hcount),
        .vcount      (vcount),
        .snap        (snap),
        .blink_phase (blink_phase),
        .frame_tick  (frame_tick)
    );

    // Lamp edges are constants, so each horizontal hit is a pair of constant compares.
    for (genvar gi = 0; gi < NUM_LIGHTS; gi++) begin : g_lamp
        localparam int         XI   = light_x(gi, LIGHT0_X, PITCH, SPLIT, GROUP_GAP);
        localparam logic [9:0] X_LO = 10'(XI);
        localparam logic [9:0] X_HI = 10'(XI + BOX_W);

        if (XI < H_ACTIVE_START || XI + BOX_W > H_ACTIVE_END) begin : g_chk_x
            $fatal(1, "light_bar_gen: lamp outside the active window");
        end

        assign hit_now[gi] = (hcount >= X_LO) && (hcount < X_HI);
        assign lit[gi]     = leds_q[gi] && (!blink_q[gi] || blink_phase);
    end

    // Lamp requests are frozen for the whole frame to avoid tearing.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            leds_q  <= '0;
            blink_q <= '0;
        end else if (snap) begin
            leds_q  <= leds;
            blink_q <= blink_en;
        end
    end

    // Stage 1: geometry decode.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_s1       <= '0;
            in_band_s1   <= 1'b0;
            in_active_s1 <= 1'b0;
            bright_s1    <= 1'b0;
        end else begin
            hit_s1       <= hit_now;
            in_band_s1   <= (vcount >= V_LO) && (vcount < V_HI);
            in_active_s1 <= (hcount >= A_LO) && (hcount < A_HI);
            bright_s1    <= bright;
        end
    end

    // Lamps never overlap, so at most one hit bit is set per pixel.
    always_comb begin
        rgb_next = COL_BG_BLUE;
        if (!bright_s1 || !in_active_s1) begin
            rgb_next = COL_BLACK;
        end else if (in_band_s1 && |(hit_s1 & lit)) begin
            rgb_next = COL_LAMP_ON;
        end else if (in_band_s1 && |hit_s1) begin
            rgb_next = COL_LAMP_OFF;
        end
    end

    // Stage 2: colour select.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rgb_q      <= COL_BLACK;
            bright_out <= 1'b0;
        end else begin
            rgb_q      <= rgb_next;
            bright_out <= bright_s1;
        end
    end

    assign vga_r = rgb_q[23:16];
    assign vga_g = rgb_q[15:8];
    assign vga_b = rgb_q[7:0];

endmodule

// File: tb/tb_light_bar_gen.sv
// tb/tb_light_bar_gen.sv - scoreboard bench for light_bar_gen
module tb_light_bar_gen;

    localparam logic [23:0] BLK  = 24'h000000;
    localparam logic [23:0] BLUE = 24'h000080;
    localparam logic [23:0] YEL  = 24'hFFFF00;
    localparam logic [23:0] GREY = 24'hB2BEB5;

    typedef struct {
        logic [23:0] rgb;
        logic        bo;
        string       name;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       bright = 1'b0;
    logic [9:0] hcount = 10'd1;
    logic [9:0] vcount = 10'd500;
    logic [5:0] leds = 6'd0;
    logic [5:0] blink_en = 6'd0;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       bright_out, frame_tick;

    logic chk = 1'b0, chk_d1 = 1'b0, chk_d2 = 1'b0;
    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   tick_cnt = 0;
    int   snaps = 0;

    light_bar_gen dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .bright     (bright),
        .hcount     (hcount),
        .vcount     (vcount),
        .leds       (leds),
        .blink_en   (blink_en),
        .vga_r      (vga_r),
        .vga_g      (vga_g),
        .vga_b      (vga_b),
        .bright_out (bright_out),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        chk_d1 <= chk;
        chk_d2 <= chk_d1;
    end

    // Monitor: each presented pixel is compared two cycles after it was driven.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (frame_tick === 1'b1) tick_cnt++;
        if (chk_d2) begin
            n_cmp++;
            if (sb_q.size() == 0) begin
                n_err++;
                $display("FAIL sb_empty: output presented with no expected entry");
            end else begin
                e = sb_q.pop_front();
                if ({vga_r, vga_g, vga_b} !== e.rgb || bright_out !== e.bo) begin
                    n_err++;
                    $display("FAIL %s: got rgb=%h bo=%b, expected rgb=%h bo=%b",
                             e.name, {vga_r, vga_g, vga_b}, bright_out, e.rgb, e.bo);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, want);
        end
    endtask

    task automatic idle();
        hcount = 10'd1;
        vcount = 10'd500;
        bright = 1'b0;
        chk    = 1'b0;
    endtask

    task automatic pix(input int h, input int v, input logic b, input logic [23:0] e,
                       input string nm);
        exp_t x;
        @(negedge clk);
        hcount = 10'(h);
        vcount = 10'(v);
        bright = b;
        chk    = 1'b1;
        x.rgb = e; x.bo = b; x.name = nm;
        sb_q.push_back(x);
        @(negedge clk);
        idle();
    endtask

    task automatic snap();
        @(negedge clk);
        hcount = 10'd0;
        vcount = 10'd0;
        bright = 1'b0;
        chk    = 1'b0;
        snaps++;
        @(posedge clk);
        #1 check("tick_hi", {31'd0, frame_tick}, 32'd1);
        @(negedge clk);
        idle();
        @(posedge clk);
        #1 check("tick_lo", {31'd0, frame_tick}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        idle();
        repeat (3) @(negedge clk);
        check("reset_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        check("reset_bo", {31'd0, bright_out}, 32'd0);
        check("reset_tick", {31'd0, frame_tick}, 32'd0);
        reset_n = 1'b1;

        // Before any snapshot every lamp is unlit.
        leds = 6'b111111;
        pix(230, 240, 1'b1, GREY, "pre_snap_grey");
        snap();
        snap();
        pix(230, 240, 1'b1, YEL,  "lamp5_on");
        pix(280, 240, 1'b1, BLUE, "between_4_5");
        pix(664, 240, 1'b1, YEL,  "lamp0_on");

        // Lamp 0 edges.
        leds = 6'b000001;
        snap();
        pix(664, 229, 1'b1, YEL,  "l0_topleft");
        pix(703, 259, 1'b1, YEL,  "l0_botright");
        pix(663, 229, 1'b1, BLUE, "l0_left_out");
        pix(704, 229, 1'b1, BLUE, "l0_right_out");
        pix(664, 260, 1'b1, BLUE, "l0_below");
        pix(664, 228, 1'b1, BLUE, "l0_above");
        pix(584, 240, 1'b1, GREY, "l1_off");
        pix(384, 240, 1'b1, GREY, "l3_after_gap");
        pix(423, 240, 1'b1, GREY, "l3_right_edge");
        pix(424, 240, 1'b1, BLUE, "gap_pixel");

        // Mid-frame change is held until the next snapshot.
        leds = 6'b000000;
        snap();
        pix(224, 240, 1'b1, GREY, "l5_off");
        leds = 6'b100000;
        pix(224, 240, 1'b1, GREY, "l5_held");
        pix(263, 250, 1'b1, GREY, "l5_held_edge");
        snap();
        pix(224, 240, 1'b1, YEL,  "l5_after_snap");

        // Blanking and active window.
        leds = 6'b111111;
        snap();
        pix(664, 240, 1'b0, BLK,  "bright0_lamp");
        pix(100, 240, 1'b1, BLK,  "h100_black");
        pix(143, 240, 1'b1, BLK,  "h143_black");
        pix(144, 100, 1'b1, BLUE, "h144_bg");
        pix(783, 240, 1'b1, BLUE, "h783_bg");
        pix(784, 240, 1'b1, BLK,  "h784_black");
        pix(664, 240, 1'b1, YEL,  "bright1_lamp");

        // Mid-frame reset blacks the outputs at once.
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        hcount = 10'd664;
        vcount = 10'd240;
        bright = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_yellow", {8'd0, vga_r, vga_g, vga_b}, {8'd0, YEL});
        reset_n = 1'b0;
        #1;
        check("async_reset_rgb", {8'd0, vga_r, vga_g, vga_b}, 32'd0);
        check("async_reset_bo", {31'd0, bright_out}, 32'd0);
        @(negedge clk);
        idle();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pix(664, 240, 1'b1, GREY, "post_reset_grey");
        snap();
        pix(664, 240, 1'b1, YEL,  "post_reset_snap");

        // Blink on lamp 2: unlit for 30 frames after reset, lit for the next 30.
        do_reset();
        leds     = 6'b000100;
        blink_en = 6'b000100;
        pix(504, 240, 1'b1, GREY, "blink_k0");
        for (int k = 1; k <= 61; k++) begin
            snap();
            pix(504, 240, 1'b1, ((k / 30) % 2 == 1) ? YEL : GREY, $sformatf("blink_k%0d", k));
        end
        pix(464, 240, 1'b1, BLUE, "blink_gap");

        repeat (4) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("tick_total", tick_cnt, snaps);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/light_bar_gen.md
Name: light_bar_gen

Overview:
Parametrised VGA pixel generator that draws a row of NUM_LIGHTS square indicator lamps, split into a left and a right group, on a blue background. It is the registered successor to the combinational Tbird light renderer. New features over that renderer:
- LED state is snapshotted once per frame, so there is no tearing.
- Each light has a per-light blink mode driven by a frame counter.
- Lamp geometry is set by parameters.
- Output passes through a two-stage pixel pipeline.

The block sits between the VGA timing controller (hcount, vcount, bright) and the RGB pins.

Parameters:
- NUM_LIGHTS, 6, number of lamps (1..16); lamp 0 is rightmost.
- SPLIT, 3, lamps 0..SPLIT-1 form the right group; the rest form the left group.
- LIGHT0_X, 664, left edge (hcount) of lamp 0.
- PITCH, 80, horizontal distance between adjacent lamps in one group; must be >= BOX_W.
- GROUP_GAP, 40, extra gap inserted between the two groups.
- BOX_W, 40, lamp width in pixels.
- V_TOP, 229, top line (vcount) of the lamps.
- BOX_H, 31, lamp height in lines.
- SNAP_LINE, 0, vcount on which the frame snapshot occurs.
- BLINK_FRAMES, 30, number of frames per blink half-period (>= 1).

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- bright  in  1  high during the visible region, from the timing controller.
- hcount  in  10  current pixel column.
- vcount  in  10  current line.
- leds  in  NUM_LIGHTS  lamp on-request, one bit per lamp.
- blink_en  in  NUM_LIGHTS  per-lamp blink-mode enable.
- vga_r  out  8  red.
- vga_g  out  8  green.
- vga_b  out  8  blue.
- bright_out  out  1  bright delayed to align with the RGB outputs.
- frame_tick  out  1  one-cycle pulse on the cycle after each snapshot.

Behaviour:
- Clocking and reset: single clock domain. Reset is asynchronous and active-low; it is applied asynchronously and released synchronously to clk.
- Reset values: vga_r, vga_g, vga_b = 0; bright_out = 0; frame_tick = 0; leds_q = 0; blink_q = 0; frame_cnt = 0; blink_phase = 0.
- Snapshot: on the cycle where hcount==0 and vcount==SNAP_LINE:
  - leds_q <= leds and blink_q <= blink_en.
  - frame_cnt increments. When frame_cnt reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
  - frame_tick=1 on the next cycle.
- Snapshot boundary conditions: changes to leds or blink_en mid-frame have no visible effect until the next snapshot. Reset mid-frame blacks the outputs immediately; nothing is displayed as lit until the first snapshot after reset.
- Lamp enable: lit[i] = leds_q[i] && (!blink_q[i] || blink_phase). Because blink_phase resets to 0, a blinking lamp is dark for the first BLINK_FRAMES frames after reset.
- Geometry:
  - Lamp i left edge X(i) = LIGHT0_X - i*PITCH - (i >= SPLIT ? GROUP_GAP : 0). All X(i) are elaboration-time constants.
  - Horizontal hit: X(i) <= hcount < X(i)+BOX_W (half-open interval).
  - Vertical band: V_TOP <= vcount < V_TOP+BOX_H.
  - Active window: H_ACTIVE_START <= hcount < H_ACTIVE_END.
- Pipeline, stage 1 (registered): hit vector, in_band, in_active, bright.
- Pipeline, stage 2 (registered): colour selection, chosen by the first matching rule:
  - Stage-1 bright == 0: black 00/00/00.
  - Not in_active: black.
  - in_band and hit[i] with lit[i]: lamp-on yellow FF/FF/00.
  - in_band and hit[i] with lamp not lit: lamp-off grey B2/BE/B5.
  - Otherwise: background 00/00/80.
- Latency and alignment: exactly 2 clk cycles from hcount, vcount, bright to RGB. bright_out is bright delayed by 2 cycles.
- Snapshot/pipeline hazard: stage 2 uses the lit[] value current at stage-2 evaluation. The snapshot line is outside the lamp band, so no pixel straddles a snapshot.
- Elaboration checks: fatal error if PITCH < BOX_W, SPLIT > NUM_LIGHTS, NUM_LIGHTS > 16, or any X(i) < H_ACTIVE_START or X(i)+BOX_W > H_ACTIVE_END.

Decomposition:
- Package vga_pkg holds:
  - H_ACTIVE_START = 144 and H_ACTIVE_END = 784.
  - 24-bit colour constants COL_BLACK, COL_BG_BLUE, COL_LAMP_ON, COL_LAMP_OFF.
  - The function light_x(i) implementing the X(i) formula.
- One sub-module, frame_blink_timer, owns the snapshot detection, frame_cnt, blink_phase and frame_tick.
- Lamp decode and the pipeline stay in light_bar_gen.

Test Plan:
- Reset, then leds=6'b111111 and blink_en=0. Two frames later, pixel (hcount 230, vcount 240) reads FF/FF/00 two cycles after it is presented, and pixel (280, 240) reads 00/00/80.
- leds=6'b000001. Pixel (664, 229) is yellow; (663, 229), (704, 229) and (664, 260) are blue; (584, 240) is grey B2/BE/B5.
- Change leds from 0 to 6'b100000 at vcount 240, mid-frame. Lamp 5 stays grey for the remainder of that frame and turns yellow after the next snapshot.
- blink_en[2]=1, leds[2]=1, BLINK_FRAMES=30. Lamp 2 is grey for frames 1-30 after reset, yellow for frames 31-60, then alternates; frame_tick pulses exactly once per frame.
- bright=0 over lamp 0 with leds=all-ones gives RGB 00/00/00; hcount 100 gives black; bright_out tracks bright with 2 cycles of delay.
- Assert reset_n low at vcount 240. RGB goes 0 immediately. After release, lamps are grey until the first snapshot, then reflect leds.
